// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - Size encodings, FSM states, lane masks and alignment helpers for the store path.
package store_pkg;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;

    localparam logic [3:0] LANE_WORD    = 4'b1111;
    localparam logic [3:0] LANE_HALF_LO = 4'b0011;
    localparam logic [3:0] LANE_HALF_HI = 4'b1100;
    localparam logic [3:0] LANE_BYTE0   = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_MERGE = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    // Reserved size 3 is treated as never aligned so it is rejected.
    function automatic logic size_aligned(input logic [1:0] size, input logic [1:0] offset);
        logic ok;
        case (size)
            SZ_WORD: ok = (offset == 2'b00);
            SZ_HALF: ok = ~offset[0];
            SZ_BYTE: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] expand_mask(input logic [3:0] mask);
        logic [31:0] bits;
        for (int k = 0; k < 4; k++) begin
            bits[8*k +: 8] = {8{mask[k]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/store_merge.sv
// rtl/store_merge.sv - Combinational little-endian lane merge and data replication for stores.
module store_merge
    import store_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] data,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    output logic [31:0] new_word,
    output logic [31:0] rep_word,
    output logic [3:0]  byte_mask
);

    logic [31:0] bit_mask;

    always_comb begin
        byte_mask = 4'b0000;
        rep_word  = data;
        case (size)
            SZ_WORD: begin
                byte_mask = LANE_WORD;
                rep_word  = data;
            end
            SZ_HALF: begin
                byte_mask = offset[1] ? LANE_HALF_HI : LANE_HALF_LO;
                rep_word  = {2{data[15:0]}};
            end
            SZ_BYTE: begin
                byte_mask = LANE_BYTE0 << offset;
                rep_word  = {4{data[7:0]}};
            end
            default: begin
                byte_mask = 4'b0000;
                rep_word  = data;
            end
        endcase
        bit_mask = expand_mask(byte_mask);
        new_word = (old_word & ~bit_mask) | (rep_word & bit_mask);
    end

endmodule

// File: rtl/store_rmw.sv
// rtl/store_rmw.sv - MEM-stage store sequencer; MEM_BYTE_WE_EN selects byte-enable writes instead of read-modify-write.
module store_rmw
    import store_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
`ifdef MEM_BYTE_WE_EN
    output logic [3:0]        mem_be,
`endif
    output logic              done,
    output logic              align_err,
    output logic              stall
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              done_q, done_d;
    logic              align_err_q, align_err_d;

    logic        accept;
    logic        req_ok;
    logic [31:0] merge_old, merge_data, new_word, rep_word;
    logic [1:0]  merge_offset, merge_size;
    logic [3:0]  byte_mask;

`ifdef MEM_BYTE_WE_EN
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] unused_rdata;

    // Lanes are selected straight from the incoming request; no read phase exists.
    assign merge_old    = 32'h0;
    assign merge_data   = req_data;
    assign merge_offset = req_addr[1:0];
    assign merge_size   = req_size;
    assign unused_rdata = mem_rdata ^ new_word;
    assign mem_be       = mem_be_q;
`else
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [1:0]        size_q, size_d;
    logic [35:0]       unused_merge;

    assign merge_old    = mem_rdata;
    assign merge_data   = data_q;
    assign merge_offset = addr_q[1:0];
    assign merge_size   = size_q;
    assign unused_merge = {rep_word, byte_mask};
`endif

    store_merge u_merge (
        .old_word  (merge_old),
        .data      (merge_data),
        .offset    (merge_offset),
        .size      (merge_size),
        .new_word  (new_word),
        .rep_word  (rep_word),
        .byte_mask (byte_mask)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign stall     = ~req_ready;
    assign accept    = req_valid && req_ready;
    assign req_ok    = size_aligned(req_size, req_addr[1:0]);

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = '0;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_wdata_d = 32'h0;
        done_d      = 1'b0;
        align_err_d = 1'b0;
`ifdef MEM_BYTE_WE_EN
        mem_be_d    = 4'b0000;
`else
        addr_d      = addr_q;
        data_d      = data_q;
        size_d      = size_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept && !req_ok) begin
                    align_err_d = 1'b1;
                end else if (accept) begin
                    mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
`ifdef MEM_BYTE_WE_EN
                    state_d     = ST_WRITE;
                    mem_wr_d    = 1'b1;
                    done_d      = 1'b1;
                    mem_wdata_d = rep_word;
                    mem_be_d    = byte_mask;
`else
                    addr_d = req_addr;
                    data_d = req_data;
                    size_d = req_size;
                    if (req_size == SZ_WORD) begin
                        state_d     = ST_WRITE;
                        mem_wr_d    = 1'b1;
                        done_d      = 1'b1;
                        mem_wdata_d = req_data;
                    end else begin
                        state_d  = ST_READ;
                        mem_rd_d = 1'b1;
                    end
`endif
                end
            end
`ifndef MEM_BYTE_WE_EN
            // Read strobe is out this cycle; memory returns the word during MERGE.
            ST_READ: state_d = ST_MERGE;
            ST_MERGE: begin
                state_d     = ST_WRITE;
                mem_addr_d  = {addr_q[ADDR_W-1:2], 2'b00};
                mem_wr_d    = 1'b1;
                done_d      = 1'b1;
                mem_wdata_d = new_word;
            end
`endif
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= 32'h0;
            done_q      <= 1'b0;
            align_err_q <= 1'b0;
`ifdef MEM_BYTE_WE_EN
            mem_be_q    <= 4'b0000;
`else
            addr_q      <= '0;
            data_q      <= 32'h0;
            size_q      <= SZ_WORD;
`endif
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            align_err_q <= align_err_d;
`ifdef MEM_BYTE_WE_EN
            mem_be_q    <= mem_be_d;
`else
            addr_q      <= addr_d;
            data_q      <= data_d;
            size_q      <= size_d;
`endif
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign align_err = align_err_q;

endmodule

// File: tb/tb_store_rmw.sv
// tb/tb_store_rmw.sv - Directed self-checking bench for store_rmw with a synchronous word memory model.
module tb_store_rmw;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata;
    logic        mem_wr;
    logic [31:0] mem_wdata;
`ifdef MEM_BYTE_WE_EN
    logic [3:0]  mem_be;
`endif
    logic        done;
    logic        align_err;
    logic        stall;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [256];
    logic        load_en;
    logic [7:0]  load_idx;
    logic [31:0] load_val;

    store_rmw #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
`ifdef MEM_BYTE_WE_EN
        .mem_be    (mem_be),
`endif
        .done      (done),
        .align_err (align_err),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_en) mem[load_idx] <= load_val;
        else if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr[9:2]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
    endtask

    task automatic idle_req();
        req_valid = 1'b0;
        req_addr  = 32'h0;
        req_data  = 32'h0;
        req_size  = 2'd0;
    endtask

    task automatic mem_load(input logic [7:0] idx, input logic [31:0] val);
        load_en = 1'b1; load_idx = idx; load_val = val;
        step();
        load_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", req_ready); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b exp 0", stall); end
        checks++; if ({mem_rd, mem_wr, done, align_err} !== 4'b0000) begin errors++; $display("FAIL rst_strobes: got %b exp 0000", {mem_rd, mem_wr, done, align_err}); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h exp 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h exp 0", mem_wdata); end
`ifdef MEM_BYTE_WE_EN
        checks++; if (mem_be !== 4'b0000) begin errors++; $display("FAIL rst_be: got %b exp 0000", mem_be); end
`endif
        rst = 1'b0;
        step();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b exp 1", req_ready); end
    endtask

    task automatic test_word();
        drive(32'h100, 32'hDEADBEEF, 2'd0);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL word_accept_ready: got %b exp 1", req_ready); end
        step();
        idle_req();
        checks++; if ({mem_wr, done, mem_rd} !== 3'b110) begin errors++; $display("FAIL word_strobes: got %b exp 110", {mem_wr, done, mem_rd}); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL word_addr: got %h exp 00000100", mem_addr); end
        checks++; if (mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL word_wdata: got %h exp deadbeef", mem_wdata); end
        checks++; if ({req_ready, stall} !== 2'b01) begin errors++; $display("FAIL word_busy: got %b exp 01", {req_ready, stall}); end
`ifdef MEM_BYTE_WE_EN
        checks++; if (mem_be !== 4'b1111) begin errors++; $display("FAIL word_be: got %b exp 1111", mem_be); end
`endif
        step();
        checks++; if ({req_ready, mem_wr, done} !== 3'b100) begin errors++; $display("FAIL word_after: got %b exp 100", {req_ready, mem_wr, done}); end
    endtask

`ifndef MEM_BYTE_WE_EN
    task automatic test_subword();
        logic [31:0] addrs [5] = '{32'h103, 32'h100, 32'h101, 32'h102, 32'h100};
        logic [31:0] datas [5] = '{32'h000000AA, 32'h0000005A, 32'hFFFFFF77, 32'h1234BEEF, 32'h0000CAFE};
        logic [1:0]  sizes [5] = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd1};
        logic [31:0] exps  [5] = '{32'hAA223344, 32'h1122335A, 32'h11227744, 32'hBEEF3344, 32'h1122CAFE};
        for (int i = 0; i < 5; i++) begin
            mem_load(8'h40, 32'h11223344);
            drive(addrs[i], datas[i], sizes[i]);
            step();
            idle_req();
            checks++; if ({mem_rd, mem_wr} !== 2'b10) begin errors++; $display("FAIL sub%0d_rd: got %b exp 10", i, {mem_rd, mem_wr}); end
            checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL sub%0d_rdaddr: got %h exp 00000100", i, mem_addr); end
            step();
            checks++; if ({mem_rd, mem_wr, stall} !== 3'b001) begin errors++; $display("FAIL sub%0d_merge: got %b exp 001", i, {mem_rd, mem_wr, stall}); end
            step();
            checks++; if ({mem_wr, done, mem_rd} !== 3'b110) begin errors++; $display("FAIL sub%0d_wr: got %b exp 110", i, {mem_wr, done, mem_rd}); end
            checks++; if (mem_wdata !== exps[i]) begin errors++; $display("FAIL sub%0d_wdata: got %h exp %h", i, mem_wdata, exps[i]); end
            step();
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL sub%0d_ready: got %b exp 1", i, req_ready); end
        end
    endtask

    task automatic test_back_to_back();
        drive(32'h108, 32'hA1B2C3D4, 2'd0);
        step();
        idle_req();
        step();
        drive(32'h109, 32'h000000EE, 2'd2);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b exp 1", req_ready); end
        step();
        idle_req();
        step();
        step();
        checks++; if (mem_wr !== 1'b1 || mem_wdata !== 32'hA1B2EED4) begin errors++; $display("FAIL b2b_wdata: got wr=%b %h exp wr=1 a1b2eed4", mem_wr, mem_wdata); end
        step();
    endtask

    task automatic test_reset_in_merge();
        int wr_seen = 0;
        mem_load(8'h44, 32'h11223344);
        drive(32'h110, 32'h00000099, 2'd2);
        step();
        idle_req();
        checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL rim_rd: got %b exp 1", mem_rd); end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if ({req_ready, stall, mem_wr, done} !== 4'b1000) begin errors++; $display("FAIL rim_state: got %b exp 1000", {req_ready, stall, mem_wr, done}); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL rim_outputs: got %h %h exp 0 0", mem_addr, mem_wdata); end
        for (int i = 0; i < 4; i++) begin
            if (mem_wr !== 1'b0) wr_seen++;
            step();
        end
        checks++; if (wr_seen != 0) begin errors++; $display("FAIL rim_no_write: got %0d writes exp 0", wr_seen); end
        checks++; if (mem[8'h44] !== 32'h11223344) begin errors++; $display("FAIL rim_mem: got %h exp 11223344", mem[8'h44]); end
    endtask
`else
    task automatic test_byte_enable();
        logic [31:0] addrs [3] = '{32'h102, 32'h102, 32'h101};
        logic [31:0] datas [3] = '{32'h00000055, 32'h1234BEEF, 32'hFFFFFF77};
        logic [1:0]  sizes [3] = '{2'd2, 2'd1, 2'd2};
        logic [31:0] exps  [3] = '{32'h55555555, 32'hBEEFBEEF, 32'h77777777};
        logic [3:0]  bes   [3] = '{4'b0100, 4'b1100, 4'b0010};
        for (int i = 0; i < 3; i++) begin
            drive(addrs[i], datas[i], sizes[i]);
            step();
            idle_req();
            checks++; if ({mem_wr, done, mem_rd} !== 3'b110) begin errors++; $display("FAIL be%0d_strobes: got %b exp 110", i, {mem_wr, done, mem_rd}); end
            checks++; if (mem_be !== bes[i]) begin errors++; $display("FAIL be%0d_be: got %b exp %b", i, mem_be, bes[i]); end
            checks++; if (mem_wdata !== exps[i] || mem_addr !== 32'h100) begin errors++; $display("FAIL be%0d_data: got %h @%h exp %h @00000100", i, mem_wdata, mem_addr, exps[i]); end
            step();
            checks++; if ({req_ready, mem_be} !== 5'b10000) begin errors++; $display("FAIL be%0d_after: got %b exp 10000", i, {req_ready, mem_be}); end
        end
    endtask
`endif

    task automatic test_misaligned();
        logic [31:0] addrs [4] = '{32'h101, 32'h102, 32'h100, 32'h103};
        logic [1:0]  sizes [4] = '{2'd1, 2'd0, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) begin
            drive(addrs[i], 32'h12345678, sizes[i]);
            step();
            idle_req();
            checks++; if ({align_err, req_ready, mem_rd, mem_wr} !== 4'b1100) begin errors++; $display("FAIL mis%0d_pulse: got %b exp 1100", i, {align_err, req_ready, mem_rd, mem_wr}); end
            step();
            checks++; if ({align_err, mem_rd, mem_wr} !== 3'b000) begin errors++; $display("FAIL mis%0d_clear: got %b exp 000", i, {align_err, mem_rd, mem_wr}); end
        end
        drive(32'h101, 32'h0, 2'd1);
        step();
        drive(32'h104, 32'h0BADF00D, 2'd0);
        checks++; if ({align_err, req_ready} !== 2'b11) begin errors++; $display("FAIL mis_then_accept_ready: got %b exp 11", {align_err, req_ready}); end
        step();
        idle_req();
        checks++; if ({mem_wr, align_err} !== 2'b10 || mem_addr !== 32'h104 || mem_wdata !== 32'h0BADF00D) begin errors++; $display("FAIL mis_then_accept_wr: got wr=%b err=%b %h %h exp 1 0 00000104 0badf00d", mem_wr, align_err, mem_addr, mem_wdata); end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        load_en = 1'b0;
        load_idx = 8'h0;
        load_val = 32'h0;
        idle_req();
        test_reset();
        test_word();
`ifndef MEM_BYTE_WE_EN
        test_subword();
        test_back_to_back();
`else
        test_byte_enable();
`endif
        test_misaligned();
`ifndef MEM_BYTE_WE_EN
        test_reset_in_merge();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
